// File: rtl/vedic_pkg.sv
// Shared types and elaboration helpers for the iterative Vedic multiplier.
// The NEG state exists only when VEDIC_MULT_SIGNED_EN is defined.
package vedic_pkg;

`ifdef VEDIC_MULT_SIGNED_EN
  typedef enum logic [1:0] {IDLE, CALC, NEG, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
`endif

  // Chunk index width, never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_legal(input int unsigned dw, input int unsigned cw);
    return (cw >= 2) && ((cw & (cw - 1)) == 0) && (dw >= cw) && ((dw % cw) == 0);
  endfunction

endpackage

// File: rtl/vedic_chunk_mul.sv
// Combinational CHUNK_WIDTH x CHUNK_WIDTH Urdhva-Tiryagbhyam multiplier:
// vertical/crosswise column sums, then carries resolved by the weighted add.
module vedic_chunk_mul
  import vedic_pkg::*;
#(
  parameter int CHUNK_WIDTH = 4
) (
  input  logic [CHUNK_WIDTH-1:0]   a_i,
  input  logic [CHUNK_WIDTH-1:0]   b_i,
  output logic [2*CHUNK_WIDTH-1:0] p_o
);

  localparam int PW = 2 * CHUNK_WIDTH;
  localparam int CW = $clog2(CHUNK_WIDTH) + 1;

  always_comb begin
    logic [CW-1:0] col [PW-1];
    for (int unsigned k = 0; k < PW - 1; k++) col[k] = '0;
    for (int unsigned i = 0; i < CHUNK_WIDTH; i++) begin
      for (int unsigned j = 0; j < CHUNK_WIDTH; j++) begin
        col[i+j] = col[i+j] + CW'(a_i[i] & b_i[j]);
      end
    end
    p_o = '0;
    for (int unsigned k = 0; k < PW - 1; k++) begin
      p_o = p_o + (PW'(col[k]) << k);
    end
  end

endmodule

// File: rtl/vedic_mult_seq.sv
// Iterative Vedic multiplier: one chunk product per cycle, accumulated over N*N steps.
// Optional two's-complement mode via VEDIC_MULT_SIGNED_EN (adds inSigned port and NEG state).
module vedic_mult_seq
  import vedic_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int CHUNK_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   inData_A,
  input  logic [DATA_WIDTH-1:0]   inData_B,
`ifdef VEDIC_MULT_SIGNED_EN
  input  logic                    inSigned,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] outData_C,
  output logic                    busy
);

  localparam int N  = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IW = int'(idx_width(N));
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (!params_legal(DATA_WIDTH, CHUNK_WIDTH)) begin : g_bad_params
    $error("vedic_mult_seq: DATA_WIDTH must be a multiple of a power-of-two CHUNK_WIDTH >= 2");
  end

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0]          acc_q, acc_d, c_q, c_d;
  logic [IW-1:0]          i_q, i_d, j_q, j_d;
`ifdef VEDIC_MULT_SIGNED_EN
  logic                   sgn_q, sgn_d, neg_q, neg_d;

  function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? -v : v;
  endfunction
`endif

  logic [CHUNK_WIDTH-1:0]   a_chunk, b_chunk;
  logic [2*CHUNK_WIDTH-1:0] pp;
  logic [31:0]              shamt;
  logic [PW-1:0]            pp_ext;

  assign a_chunk = a_q[i_q*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign b_chunk = b_q[j_q*CHUNK_WIDTH +: CHUNK_WIDTH];
  // i+j can exceed the index width, so the shift is formed at 32 bits
  assign shamt   = (32'(i_q) + 32'(j_q)) * 32'(CHUNK_WIDTH);
  assign pp_ext  = PW'(pp) << shamt;

  vedic_chunk_mul #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_chunk (
    .a_i(a_chunk),
    .b_i(b_chunk),
    .p_o(pp)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    c_d       = c_q;
    i_d       = i_q;
    j_d       = j_q;
`ifdef VEDIC_MULT_SIGNED_EN
    sgn_d     = sgn_q;
    neg_d     = neg_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = inData_A;
          b_d     = inData_B;
`ifdef VEDIC_MULT_SIGNED_EN
          sgn_d   = inSigned;
          neg_d   = inSigned & (inData_A[DATA_WIDTH-1] ^ inData_B[DATA_WIDTH-1]);
          if (inSigned) begin
            a_d = mag(inData_A);
            b_d = mag(inData_B);
          end
`endif
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        busy  = 1'b1;
        acc_d = acc_q + pp_ext;
        if (j_q == LAST) begin
          j_d = '0;
          i_d = i_q + IW'(1);
        end else begin
          j_d = j_q + IW'(1);
        end
        if (i_q == LAST && j_q == LAST) begin
          i_d = '0;
`ifdef VEDIC_MULT_SIGNED_EN
          if (sgn_q) begin
            state_d = NEG;
          end else begin
            c_d     = acc_d;
            state_d = DONE;
          end
`else
          c_d     = acc_d;
          state_d = DONE;
`endif
        end
      end
`ifdef VEDIC_MULT_SIGNED_EN
      NEG: begin
        busy = 1'b1;
        if (neg_q) acc_d = -acc_q;
        c_d     = acc_d;
        state_d = DONE;
      end
`endif
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
`ifdef VEDIC_MULT_SIGNED_EN
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      i_q     <= i_d;
      j_q     <= j_d;
`ifdef VEDIC_MULT_SIGNED_EN
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
`endif
    end
  end

  assign outData_C = c_q;

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Self-checking bench for vedic_mult_seq: vector table plus random vectors against
// an arithmetic reference, and directed backpressure / reset / width sequences.
module tb_vedic_mult_seq;

  localparam int STEPS = 16;
`ifdef VEDIC_MULT_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy, in_signed;
  logic [15:0] a, b;
  logic [31:0] c;

  logic        iv8, ir8, ov8, bz8, iv12, ir12, ov12, bz12;
  logic [7:0]  a8, b8;
  logic [15:0] c8;
  logic [11:0] a12, b12;
  logic [23:0] c12;
  logic        one = 1'b1;
  logic        zero = 1'b0;

  int errors = 0;
  int checks = 0;

  vedic_mult_seq #(.DATA_WIDTH(16), .CHUNK_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inData_A(a), .inData_B(b),
`ifdef VEDIC_MULT_SIGNED_EN
    .inSigned(in_signed),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .outData_C(c), .busy(busy)
  );

  vedic_mult_seq #(.DATA_WIDTH(8), .CHUNK_WIDTH(4)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .inData_A(a8), .inData_B(b8),
`ifdef VEDIC_MULT_SIGNED_EN
    .inSigned(zero),
`endif
    .out_valid(ov8), .out_ready(one), .outData_C(c8), .busy(bz8)
  );

  vedic_mult_seq #(.DATA_WIDTH(12), .CHUNK_WIDTH(4)) u12 (
    .clk(clk), .rst(rst), .in_valid(iv12), .in_ready(ir12),
    .inData_A(a12), .inData_B(b12),
`ifdef VEDIC_MULT_SIGNED_EN
    .inSigned(zero),
`endif
    .out_valid(ov12), .out_ready(one), .outData_C(c12), .busy(bz12)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sg;
    logic [31:0] exp;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic sg);
    longint sx, sy;
    if (sg) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'(x);
      sy = longint'(y);
    end
    return 32'(sx * sy);
  endfunction

  function automatic int ref_lat(input logic sg);
    return STEPS + 1 + (sg ? 1 : 0);
  endfunction

  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic sg, input string nm);
    @(negedge clk);
    check({nm, " in_ready"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1; a = x; b = y; in_signed = sg;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // latency counts the accepting edge as 1; returns positioned at the negedge showing out_valid
  task automatic wait_done(input string nm, output int lat);
    bit seen;
    seen = 1'b0;
    lat = 1;
    while (!seen && lat < 200) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!seen) check({nm, " timeout"}, 64'(0), 64'(1));
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    start_op(v.a, v.b, v.sg, v.nm);
    wait_done(v.nm, lat);
    check({v.nm, " product"}, 64'(c), 64'(v.exp));
    check({v.nm, " latency"}, 64'(lat), 64'(v.lat));
    @(negedge clk);
    check({v.nm, " out_valid one cycle"}, 64'(out_valid), 64'(0));
    check({v.nm, " hold after handshake"}, 64'(c), 64'(v.exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    int stray;
    logic [15:0] x, y;
    logic s;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; in_signed = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; iv12 = 1'b0; a12 = '0; b12 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'(1));
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset outData_C", 64'(c), 64'(0));
    rst = 1'b0;

    vt.push_back('{16'h1234, 16'h5678, 1'b0, 32'h06260060, 17, "dir_1234x5678"});
    vt.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 17, "dir_ffffxffff"});
    vt.push_back('{16'h0000, 16'hBEEF, 1'b0, 32'h00000000, 17, "dir_0xbeef"});
    vt.push_back('{16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE, 17, "dir_u_ffffx2"});
`ifdef VEDIC_MULT_SIGNED_EN
    vt.push_back('{16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, 18, "dir_s_m1x2"});
    vt.push_back('{16'h8000, 16'h8000, 1'b1, 32'h40000000, 18, "dir_s_minsq"});
    vt.push_back('{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 18, "dir_s_minx1"});
`endif
    for (int i = 0; i < 14; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      s = SIGNED_BUILD ? 1'($urandom_range(0, 1)) : 1'b0;
      vt.push_back('{x, y, s, ref_mul(x, y, s), ref_lat(s), $sformatf("rnd%0d", i)});
    end
    foreach (vt[k]) run_vec(vt[k]);

    // backpressure: result held, new operands refused until the handshake
    out_ready = 1'b0;
    start_op(16'h1234, 16'h0003, 1'b0, "bp");
    wait_done("bp", lat);
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h0002; in_signed = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp out_valid held", 64'(out_valid), 64'(1));
      check("bp data held", 64'(c), 64'(ref_mul(16'h1234, 16'h0003, 1'b0)));
      check("bp in_ready low", 64'(in_ready), 64'(0));
      check("bp busy", 64'(busy), 64'(1));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp out_valid dropped", 64'(out_valid), 64'(0));
    check("bp back to idle", 64'(in_ready), 64'(1));
    check("bp data kept", 64'(c), 64'(32'h0000369C));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done("bp_next", lat);
    check("bp_next product", 64'(c), 64'(ref_mul(16'hAAAA, 16'h0002, 1'b0)));
    check("bp_next latency", 64'(lat), 64'(17));

    // reset during CALC aborts the operation
    start_op(16'h00FF, 16'h0101, 1'b0, "rst_mid");
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("rst_mid busy", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid in_ready", 64'(in_ready), 64'(1));
    check("rst_mid out_valid", 64'(out_valid), 64'(0));
    check("rst_mid outData_C", 64'(c), 64'(0));
    stray = 0;
    for (int k = 0; k < STEPS + 4; k++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("rst_mid no result", 64'(stray), 64'(0));
    run_vec('{16'h0003, 16'h0005, 1'b0, 32'd15, 17, "after_rst_3x5"});

    // 8-bit instance: N=2, four steps
    @(negedge clk);
    check("w8 in_ready", 64'(ir8), 64'(1));
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 1; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      if (ov8) seen = 1'b1;
      else begin @(posedge clk); lat++; end
    end
    check("w8 seen", 64'(seen), 64'(1));
    check("w8 product", 64'(c8), 64'(16'hFE01));
    check("w8 latency", 64'(lat), 64'(5));

    // 12-bit instance: N=3 is not a power of two
    @(negedge clk);
    iv12 = 1'b1; a12 = 12'hABC; b12 = 12'h123;
    @(posedge clk); #1;
    iv12 = 1'b0;
    lat = 1; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      if (ov12) seen = 1'b1;
      else begin @(posedge clk); lat++; end
    end
    check("w12 seen", 64'(seen), 64'(1));
    check("w12 product", 64'(c12), 64'(24'(2748 * 291)));
    check("w12 latency", 64'(lat), 64'(10));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
